subset_scheduler: RTL

Top-level sequencer for the per-subset DIC flow. After parameter load it reads the subset count from the parameter BRAM header, then steps subset numbers 0..N-1 through the subset interface and a downstream correlation engine. It owns the parameter BRAM read port: the scheduler drives it while fetching the header and passes the subset interface's port through at all other times.

---
 rtl/dice_pkg.sv | 28 ++
 rtl/param_port_mux.sv | 39 +++
 rtl/subset_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dice_pkg                                                             |
// | Shared types and constants for the per-subset DIC flow.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dice_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_HDR_ADDR   = 4'd1,
    S_HDR_W1     = 4'd2,
    S_HDR_W2     = 4'd3,
    S_HDR_CAP    = 4'd4,
    S_ISSUE      = 4'd5,
    S_WAIT_COORD = 4'd6,
    S_START_CORR = 4'd7,
    S_WAIT_CORR  = 4'd8,
    S_NEXT       = 4'd9,
    S_FINISH     = 4'd10
  } sched_state_t;

  localparam int unsigned BRAM_RD_LATENCY     = 3;
  localparam logic [31:0] HEADER_ADDR_DEFAULT = 32'd0;
  localparam int unsigned WORD_BYTE_SHIFT     = 2;

endpackage : dice_pkg
`default_nettype wire

// File: rtl/param_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_port_mux                                                       |
// | Registered 2:1 mux of the parameter BRAM read port.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module param_port_mux (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_sched_owns_port,
  input  logic        i_sched_ea,
  input  logic [3:0]  i_sched_wea,
  input  logic [31:0] i_sched_addr,
  input  logic        i_intr_ea,
  input  logic [3:0]  i_intr_wea,
  input  logic [31:0] i_intr_addr,
  output logic        o_param_ea,
  output logic [3:0]  o_param_wea,
  output logic [31:0] o_param_addr
);

  always_ff @(posedge clock) begin
    if (reset) begin
      o_param_ea   <= 1'b0;
      o_param_wea  <= 4'd0;
      o_param_addr <= 32'd0;
    end else if (i_sched_owns_port) begin
      o_param_ea   <= i_sched_ea;
      o_param_wea  <= i_sched_wea;
      o_param_addr <= i_sched_addr;
    end else begin
      o_param_ea   <= i_intr_ea;
      o_param_wea  <= i_intr_wea;
      o_param_addr <= i_intr_addr;
    end
  end

endmodule : param_port_mux
`default_nettype wire

// File: rtl/subset_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | subset_scheduler                                                     |
// | Reads the subset count header, then steps each subset through the   |
// | subset interface and the correlation engine.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module subset_scheduler
  import dice_pkg::*;
#(
  parameter logic [31:0] HEADER_ADDR = HEADER_ADDR_DEFAULT,
  parameter logic [31:0] MAX_SUBSETS = 32'd65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        parameters_done,
  input  logic        start,
  output logic        param_ea,
  output logic [3:0]  param_wea,
  output logic [31:0] param_addr,
  input  logic [31:0] param_dout,
  input  logic        intr_param_ea,
  input  logic [3:0]  intr_param_wea,
  input  logic [31:0] intr_param_addr,
  output logic        coord_new_subset,
  output logic [31:0] coord_subset_number,
  input  logic        coord_interface_done,
  output logic        corr_start,
  input  logic        corr_done,
  output logic [31:0] num_subsets,
  output logic        busy,
  output logic        all_done,
  output logic        count_clamped
);

  sched_state_t r_state;
  logic         r_seen_low;
  logic         w_owns_port;
  logic         w_over;
  logic [31:0]  w_clamped;
  logic [32:0]  w_next_number;

  assign w_owns_port   = (r_state == S_HDR_ADDR) || (r_state == S_HDR_W1) ||
                         (r_state == S_HDR_W2)   || (r_state == S_HDR_CAP);
  assign w_over        = (param_dout > MAX_SUBSETS);
  assign w_clamped     = w_over ? MAX_SUBSETS : param_dout;
  // Widened so the last-subset compare cannot wrap at 2^32-1.
  assign w_next_number = {1'b0, coord_subset_number} + 33'd1;

  param_port_mux u_port_mux (
    .clock             (clock),
    .reset             (reset),
    .i_sched_owns_port (w_owns_port),
    .i_sched_ea        (1'b1),
    .i_sched_wea       (4'd0),
    .i_sched_addr      (HEADER_ADDR),
    .i_intr_ea         (intr_param_ea),
    .i_intr_wea        (intr_param_wea),
    .i_intr_addr       (intr_param_addr),
    .o_param_ea        (param_ea),
    .o_param_wea       (param_wea),
    .o_param_addr      (param_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_seen_low          <= 1'b0;
      coord_new_subset    <= 1'b0;
      coord_subset_number <= 32'd0;
      corr_start          <= 1'b0;
      num_subsets         <= 32'd0;
      busy                <= 1'b0;
      all_done            <= 1'b0;
      count_clamped       <= 1'b0;
    end else begin
      coord_new_subset <= 1'b0;
      corr_start       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && parameters_done) begin
            all_done      <= 1'b0;
            count_clamped <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_HDR_ADDR;
          end
        end
        S_HDR_ADDR: r_state <= S_HDR_W1;
        S_HDR_W1:   r_state <= S_HDR_W2;
        S_HDR_W2:   r_state <= S_HDR_CAP;
        S_HDR_CAP: begin
          num_subsets <= w_clamped;
          if (w_over) begin
            count_clamped <= 1'b1;
          end
          if (w_clamped == 32'd0) begin
            r_state <= S_FINISH;
          end else begin
            coord_subset_number <= 32'd0;
            r_state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          coord_new_subset <= 1'b1;
          r_seen_low       <= 1'b0;
          r_state          <= S_WAIT_COORD;
        end
        S_WAIT_COORD: begin
          // A high level is trusted only after a low has been observed,
          // so the previous subset's done level cannot launch correlation.
          if (!coord_interface_done) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_state <= S_START_CORR;
          end
        end
        S_START_CORR: begin
          corr_start <= 1'b1;
          r_state    <= S_WAIT_CORR;
        end
        S_WAIT_CORR: begin
          if (corr_done) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_next_number == {1'b0, num_subsets}) begin
            r_state <= S_FINISH;
          end else begin
            coord_subset_number <= w_next_number[31:0];
            r_state             <= S_ISSUE;
          end
        end
        S_FINISH: begin
          all_done <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : subset_scheduler
`default_nettype wire
